// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: UART receive front end.
// Free-running 1x (transmit) and 8x (receive) baud ticks, a 2-flop rx
// synchronizer, and an 8x-oversampled start detector / bit sampler that
// majority-votes samples 3, 4 and 5 of every frame bit and strobes the
// voted value with its frame position.
// Optional feature macro: UART_RX_FRAME_ERR_EN adds the frame_err output
// and holds off start detection after a bad stop bit until the line idles.
module uart_rx_bit_sampler #(
  parameter int BAUD_RATE = 115200,
  parameter int FREQUENCY = 100000000,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx_bd_en,
  output logic       rx_bd_en,
  output logic       rx_bit,
  output logic       rx_bit_rdy,
  output logic [3:0] bit_idx,
  output logic       busy,
  output logic       false_start
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int TX_DIV = FREQUENCY / BAUD_RATE;
  localparam int RX_DIV = FREQUENCY / (8 * BAUD_RATE);
  localparam int TXW    = $clog2(TX_DIV);
  localparam int RXW    = $clog2(RX_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK   // bad stop seen; wait for the line to idle high
  } state_t;

  logic [TXW-1:0] tx_cnt_q;
  logic [RXW-1:0] rx_cnt_q;
  logic           tx_tick_q, rx_tick_q;
  logic           rx_s1_q, rx_s_q;

  state_t         state_q, state_d;
  logic [2:0]     tk_q, tk_d;
  logic [2:0]     smp_q, smp_d;
  logic           bit_q, bit_d;
  logic [3:0]     idx_q, idx_d;
  logic           rdy_q, rdy_d;
  logic           busy_q, busy_d;
  logic           fs_q, fs_d;
  logic           fe_q, fe_d;
  logic           vote;

  // Baud counters: independent, each wraps at DIV-1; tick lands the cycle after the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_tick_q <= 1'b0;
      rx_tick_q <= 1'b0;
    end else begin
      tx_tick_q <= (tx_cnt_q == TXW'(TX_DIV - 1));
      rx_tick_q <= (rx_cnt_q == RXW'(RX_DIV - 1));
      tx_cnt_q  <= (tx_cnt_q == TXW'(TX_DIV - 1)) ? '0 : tx_cnt_q + TXW'(1);
      rx_cnt_q  <= (rx_cnt_q == RXW'(RX_DIV - 1)) ? '0 : rx_cnt_q + RXW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s_q  <= rx_s1_q;
    end
  end

  // 2-of-3 majority over the mid-bit samples
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  // Sampler FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tk_q    <= '0;
      smp_q   <= '0;
      bit_q   <= 1'b1;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
    end
  end

  // Next state: advances only on 8x ticks; strobes are single-cycle
  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;

    if (rx_tick_q) begin
      // tk wraps 7->0 by width, so each bit is exactly 8 ticks
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
        tk_d = tk_q + 3'd1;
        if (tk_q == 3'd3) smp_d[0] = rx_s_q;
        if (tk_q == 3'd4) smp_d[1] = rx_s_q;
        if (tk_q == 3'd5) smp_d[2] = rx_s_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            busy_d  = 1'b1;
            tk_d    = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (tk_q == 3'd7) begin
            if (!vote) begin
              rdy_d   = 1'b1;
              bit_d   = 1'b0;
              idx_d   = '0;
              state_d = S_DATA;
            end else begin
              fs_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tk_q == 3'd7) begin
            rdy_d = 1'b1;
            bit_d = vote;
            idx_d = idx_q + 4'd1;
            if (idx_q + 4'd1 == 4'(DATA_BITS)) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (tk_q == 3'd7) begin
            rdy_d   = 1'b1;
            bit_d   = vote;
            idx_d   = 4'(DATA_BITS + 1);
            busy_d  = 1'b0;
            state_d = S_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
            if (!vote) begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
`endif
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tx_bd_en    = tx_tick_q;
  assign rx_bd_en    = rx_tick_q;
  assign rx_bit      = bit_q;
  assign rx_bit_rdy  = rdy_q;
  assign bit_idx     = idx_q;
  assign busy        = busy_q;
  assign false_start = fs_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err   = fe_q;
`else
  logic unused_fe;
  assign unused_fe   = fe_q;
`endif

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// tb_uart_rx_bit_sampler: directed bench for uart_rx_bit_sampler at default
// parameters (TX_DIV=868, RX_DIV=108). Frames are driven bit-by-bit against a
// cycle counter that restarts with reset; strobes are logged by a monitor and
// checked against hand-derived bit sequences.
module tb_uart_rx_bit_sampler;

  logic       clk, rst, rx;
  logic       tx_bd_en, rx_bd_en, rx_bit, rx_bit_rdy, busy, false_start;
  logic [3:0] bit_idx;
  logic       frame_err;

  uart_rx_bit_sampler dut (
    .clk(clk), .rst(rst), .rx(rx),
    .tx_bd_en(tx_bd_en), .rx_bd_en(rx_bd_en),
    .rx_bit(rx_bit), .rx_bit_rdy(rx_bit_rdy), .bit_idx(bit_idx),
    .busy(busy), .false_start(false_start)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );
`ifndef UART_RX_FRAME_ERR_EN
  assign frame_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since reset release; baud ticks are expected at multiples of the divisors
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {int idx; int b; int bz; int fe; int cyc;} strb_t;
  strb_t q[$];
  int fs_cnt = 0;

  // strobe logger
  always @(negedge clk) begin
    if (!rst && rx_bit_rdy)
      q.push_back('{int'(bit_idx), int'(rx_bit), int'(busy), int'(frame_err), cyc});
    if (!rst && false_start) fs_cnt <= fs_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_tx"},   int'(tx_bd_en),    0);
    chk({tag, "_rxen"}, int'(rx_bd_en),    0);
    chk({tag, "_bit"},  int'(rx_bit),      1);
    chk({tag, "_rdy"},  int'(rx_bit_rdy),  0);
    chk({tag, "_idx"},  int'(bit_idx),     0);
    chk({tag, "_busy"}, int'(busy),        0);
    chk({tag, "_fs"},   int'(false_start), 0);
  endtask

  // Drives start + 8 data (LSB first) + stop, 868 cycles per bit, starting one
  // cycle after an 8x tick. flip_c inverts rx around one drive cycle to corrupt
  // a single oversample; stop4 returns once the bit_idx=4 strobe has been logged.
  task automatic send_frame(input logic [7:0] d, input logic stp, input int flip_c, input bit stop4);
    logic [9:0] fr;
    int g;
    fr = {stp, d, 1'b0};
    g = 0;
    while (cyc % 108 != 1 && g < 300) begin @(negedge clk); g++; end
    chk("align", cyc % 108, 1);
    for (int c = 0; c < 8680; c++) begin
      rx = fr[c / 868] ^ ((c >= flip_c - 3) && (c <= flip_c + 5));
      @(negedge clk);
      if (stop4 && q.size() >= 5) begin
        rx = 1'b1;
        return;
      end
    end
    rx = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] d, input logic stp);
    int n, eb;
    n = q.size();
    chk({tag, "_nstrb"}, n, 10);
    if (n > 10) n = 10;
    for (int j = 0; j < n; j++) begin
      eb = (j == 0) ? 0 : (j <= 8) ? int'(d[j-1]) : int'(stp);
      chk($sformatf("%s_idx%0d", tag, j),  q[j].idx, j);
      chk($sformatf("%s_bit%0d", tag, j),  q[j].b,   eb);
      chk($sformatf("%s_busy%0d", tag, j), q[j].bz,  (j == 9) ? 0 : 1);
`ifdef UART_RX_FRAME_ERR_EN
      chk($sformatf("%s_ferr%0d", tag, j), q[j].fe, (j == 9 && !stp) ? 1 : 0);
`endif
      if (j > 0) chk($sformatf("%s_gap%0d", tag, j), q[j].cyc - q[j-1].cyc, 864);
    end
    chk({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int first_tx, first_rx, n_tx, n_rx, bad_tx, bad_rx, bad_idle;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_rst("reset");
    @(negedge clk);
    rst = 1'b0;

    // idle line: tick cadence and quiet outputs
    first_tx = -1; first_rx = -1; n_tx = 0; n_rx = 0;
    bad_tx = 0; bad_rx = 0; bad_idle = 0;
    while (cyc < 10000) begin
      @(negedge clk);
      if (tx_bd_en !== ((cyc > 0) && (cyc % 868 == 0))) bad_tx++;
      if (rx_bd_en !== ((cyc > 0) && (cyc % 108 == 0))) bad_rx++;
      if (busy !== 1'b0 || rx_bit_rdy !== 1'b0 || false_start !== 1'b0) bad_idle++;
      if (tx_bd_en === 1'b1) begin n_tx++; if (first_tx < 0) first_tx = cyc; end
      if (rx_bd_en === 1'b1) begin n_rx++; if (first_rx < 0) first_rx = cyc; end
    end
    chk("first_tx", first_tx, 868);
    chk("first_rx", first_rx, 108);
    chk("n_tx", n_tx, 11);
    chk("n_rx", n_rx, 92);
    chk("tx_pattern", bad_tx, 0);
    chk("rx_pattern", bad_rx, 0);
    chk("idle_quiet", bad_idle, 0);

    // 0x55 frame
    q.delete();
    send_frame(8'h55, 1'b1, -100, 1'b0);
    repeat (400) @(negedge clk);
    chk_frame("f55", 8'h55, 1'b1);

    // two consecutive all-ones frames: only the start bit is low
    for (int k = 0; k < 2; k++) begin
      q.delete();
      send_frame(8'hFF, 1'b1, -100, 1'b0);
      repeat (400) @(negedge clk);
      chk_frame($sformatf("fFF%0d", k), 8'hFF, 1'b1);
    end
    chk("fs_none", fs_cnt, 0);

    // 216-cycle low glitch: false start, no strobes
    q.delete();
    while (cyc % 108 != 1) @(negedge clk);
    rx = 1'b0;
    for (int c = 0; c < 216; c++) begin
      @(negedge clk);
      if (c == 200) chk("glitch_busy", int'(busy), 1);
    end
    rx = 1'b1;
    repeat (1200) @(negedge clk);
    chk("glitch_fs", fs_cnt, 1);
    chk("glitch_nstrb", q.size(), 0);
    chk("glitch_busy_end", int'(busy), 0);

    // reset while bit_idx=4 is held (0xA5: data bit 3 is 0, so rx_bit=0 then)
    q.delete();
    send_frame(8'hA5, 1'b1, -100, 1'b1);
    chk("abort_nstrb", q.size(), 5);
    chk("abort_idx", int'(bit_idx), 4);
    chk("abort_bit", int'(rx_bit), 0);
    rst = 1'b1;
    #1;
    chk_rst("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();

    // after reset: 0xC3 with one inverted oversample at tk=4 of data bit 0
    send_frame(8'hC3, 1'b1, 1509, 1'b0);
    repeat (400) @(negedge clk);
    chk_frame("fC3flip", 8'hC3, 1'b1);

    // stop bit driven low: rx_bit=0 at bit_idx=9 (frame_err when enabled)
    q.delete();
    send_frame(8'h3A, 1'b0, -100, 1'b0);
    repeat (400) @(negedge clk);
    chk_frame("fstop0", 8'h3A, 1'b0);
    chk("fs_total", fs_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
